data_mem_bridge: RTL and testbench

Memory-stage data-access bridge between the pipelined MIPS core's M stage and an SRAM-like data bus with `req`/`addr_ok`/`data_ok` handshake. It consumes the M-stage memory request (address from `aluoutM`, store data from `writedataM`, access type), formats byte/halfword/word stores, and sign/zero-extends loads into `readdataM`. It raises `stallreq` to the hazard unit while a bus transaction is outstanding and flags unaligned accesses as address errors instead of issuing them.

---
 rtl/data_mem_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_data_mem_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
// M-stage data-access bridge: formats MIPS loads/stores onto a req/addr_ok/data_ok
// SRAM-like bus, extends load data and stalls the pipeline while a transfer is in flight.
module data_mem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic [2:0]  memopM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  input  logic        pipe_holdM,
  output logic [31:0] readdataM,
  output logic        stallreq,
  output logic        adelM,
  output logic        adesM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  function automatic logic f_is_store(input logic [2:0] op);
    f_is_store = op[2] & (op[1] | op[0]);
  endfunction

  function automatic logic [1:0] f_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: f_size = 2'd0;
      OP_LH, OP_LHU, OP_SH: f_size = 2'd1;
      OP_LW, OP_SW:         f_size = 2'd2;
      default:              f_size = 2'd0;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: f_misaligned = a[0];
      OP_LW, OP_SW:         f_misaligned = (a != 2'b00);
      default:              f_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   f_wdata = {4{wd[7:0]}};
      OP_SH:   f_wdata = {2{wd[15:0]}};
      OP_SW:   f_wdata = wd;
      default: f_wdata = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   f_wstrb = 4'b0001 << a;
      OP_SH:   f_wstrb = a[1] ? 4'b1100 : 4'b0011;
      OP_SW:   f_wstrb = 4'b1111;
      default: f_wstrb = 4'b0000;
    endcase
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] a,
                                         input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      2'd3:    b = raw[31:24];
      default: b = raw[7:0];
    endcase
    h = a[1] ? raw[31:16] : raw[15:0];
    case (op)
      OP_LB:   f_load = {{24{b[7]}}, b};
      OP_LBU:  f_load = {24'h00_0000, b};
      OP_LH:   f_load = {{16{h[15]}}, h};
      OP_LHU:  f_load = {16'h0000, h};
      OP_LW:   f_load = raw;
      default: f_load = raw;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic [31:0] rdata_q, rdata_d;

  logic        req_valid;
  logic        misaligned;
  logic        is_store;
  logic        access;
  logic        latch_en;
  logic        req;
  logic        stall;

  // Request qualification and address-error flags.
  always_comb begin
    misaligned = f_misaligned(memopM, addrM[1:0]);
    is_store   = f_is_store(memopM);
    req_valid  = memenM & ~flushM & ~rst;
    access     = req_valid & ~misaligned;
    adelM      = req_valid & misaligned & ~is_store;
    adesM      = req_valid & misaligned & is_store;
  end

  // Next-state, handshake and load-capture logic.
  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    latch_en = 1'b0;
    req      = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          latch_en = 1'b1;
          req      = 1'b1;
          stall    = 1'b1;
          state_d  = data_addr_ok ? DATA : ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        req   = 1'b1;
        stall = 1'b1;
        if (data_addr_ok) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        stall = 1'b1;
        if (data_ok) begin
          state_d = DONE;
          if (!f_is_store(op_q)) begin
            rdata_d = f_load(op_q, addr_q[1:0], data_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        state_d = pipe_holdM ? DONE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fresh request fields are driven straight from M only in the issuing IDLE cycle.
  always_comb begin
    if (latch_en) begin
      data_wr    = is_store;
      data_size  = f_size(memopM);
      data_addr  = addrM;
      data_wdata = f_wdata(memopM, writedataM);
      data_wstrb = f_wstrb(memopM, addrM[1:0]);
    end else begin
      data_wr    = wr_q;
      data_size  = size_q;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      data_wstrb = wstrb_q;
    end
    data_req  = req & ~rst;
    stallreq  = stall & ~rst;
    readdataM = rdata_q;
  end

  // State, request copies and load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (latch_en) begin
        op_q    <= memopM;
        addr_q  <= addrM;
        wdata_q <= f_wdata(memopM, writedataM);
        wstrb_q <= f_wstrb(memopM, addrM[1:0]);
        size_q  <= f_size(memopM);
        wr_q    <= is_store;
      end else begin
        op_q    <= op_q;
        addr_q  <= addr_q;
        wdata_q <= wdata_q;
        wstrb_q <= wstrb_q;
        size_q  <= size_q;
        wr_q    <= wr_q;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed spec scenarios plus randomized
// accesses against a behavioural bus/pipeline model.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [2:0]  memopM;
  logic [31:0] addrM;
  logic [31:0] writedataM;
  logic        flushM;
  logic        pipe_holdM;
  logic [31:0] readdataM;
  logic        stallreq;
  logic        adelM;
  logic        adesM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_ok;
  logic [31:0] data_rdata;

  data_mem_bridge dut (
    .clk(clk), .rst(rst), .memenM(memenM), .memopM(memopM), .addrM(addrM),
    .writedataM(writedataM), .flushM(flushM), .pipe_holdM(pipe_holdM),
    .readdataM(readdataM), .stallreq(stallreq), .adelM(adelM), .adesM(adesM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_ok(data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rd;

  // Observations gathered by run_access
  int          o_stall_cnt, o_stall_err, o_req_cnt;
  bit          o_stable, o_rd_stable;
  logic        o_wr;
  logic [1:0]  o_size;
  logic [31:0] o_addr, o_wdata, o_rd;
  logic [3:0]  o_wstrb;

  // The hazard unit never squashes M while the bridge stalls.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_checks++;
      if (stallreq === 1'b1 && flushM === 1'b1) begin
        n_fail++;
        $display("FAIL flush_under_stall: flushM=%b while stallreq=%b", flushM, stallreq);
      end
    end
  end

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] raw);
    int unsigned off, b, h;
    off = addr % 4;
    b = (raw >> (8 * off)) % 256;
    h = (raw >> (8 * off)) % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      OP_LHU:  return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   return (wd % 256) * 32'h0101_0101;
      OP_SH:   return (wd % 65536) * 32'h0001_0001;
      OP_SW:   return wd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] op, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    case (op)
      OP_SB:   return 4'(32'd1 << off);
      OP_SH:   return 4'(32'd3 << off);
      OP_SW:   return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd2;
    endcase
  endfunction

  // One access in M: bus grants addr_ok at cycle alat, data_ok dlat cycles after DATA entry,
  // then pipe_holdM keeps the instruction in M for 'hold' extra cycles.
  task automatic run_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] raw, input int alat, input int dlat, input int hold);
    int dok_c, done_c;
    bit snap;
    dok_c  = alat + 1 + dlat;
    done_c = dok_c + 1;
    o_stall_cnt = 0; o_stall_err = 0; o_req_cnt = 0;
    o_stable = 1'b1; o_rd_stable = 1'b1; snap = 1'b0; o_rd = 32'h0;
    for (int c = 0; c <= done_c + hold; c++) begin
      memenM = 1'b1;
      flushM = 1'b0;
      if (c == 0) begin
        memopM = op; addrM = addr; writedataM = wd;
      end else begin
        memopM = 3'($urandom); addrM = $urandom; writedataM = $urandom;
      end
      data_addr_ok = (c == alat);
      data_ok      = (c == dok_c);
      data_rdata   = (c == dok_c) ? raw : $urandom;
      pipe_holdM   = (c >= done_c) && (c < done_c + hold);
      @(negedge clk);
      if (stallreq === 1'b1) o_stall_cnt++;
      if (stallreq !== ((c < done_c) ? 1'b1 : 1'b0)) o_stall_err++;
      if (data_req === 1'b1) begin
        o_req_cnt++;
        if (!snap) begin
          snap = 1'b1;
          o_wr = data_wr; o_size = data_size; o_addr = data_addr;
          o_wdata = data_wdata; o_wstrb = data_wstrb;
        end else if (data_wr !== o_wr || data_size !== o_size || data_addr !== o_addr ||
                     data_wdata !== o_wdata || data_wstrb !== o_wstrb) begin
          o_stable = 1'b0;
        end
      end
      if (c == done_c) o_rd = readdataM;
      else if (c > done_c && readdataM !== o_rd) o_rd_stable = 1'b0;
      @(posedge clk); #1;
    end
    memenM = 1'b0; data_addr_ok = 1'b0; data_ok = 1'b0; pipe_holdM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; memenM = 1'b1; memopM = OP_LW; addrM = 32'h102; flushM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (adelM !== 1'b0 || stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_force_adel: adelM=%b stallreq=%b expected 0 0", adelM, stallreq);
    end
    @(posedge clk); #1;
    memopM = OP_SW; addrM = 32'h104;
    @(negedge clk);
    n_checks++;
    if (stallreq !== 1'b0 || adesM !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_force_stall: stallreq=%b adesM=%b expected 0 0", stallreq, adesM);
    end
    @(posedge clk); #1;
    rst = 1'b0; memenM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (readdataM !== 32'h0 || data_req !== 1'b0 || data_wr !== 1'b0 || data_size !== 2'd0 ||
        data_addr !== 32'h0 || data_wdata !== 32'h0 || data_wstrb !== 4'h0 || stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: rd=%h req=%b wr=%b size=%0d addr=%h wdata=%h wstrb=%b stall=%b expected all 0",
               readdataM, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, stallreq);
    end
    @(posedge clk); #1;
    model_rd = 32'h0;
  endtask

  task automatic test_loads();
    logic [2:0]  ops [3] = '{OP_LB, OP_LBU, OP_LH};
    logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011};
    run_access(OP_LW, 32'h100, $urandom, 32'hDEAD_BEEF, 0, 0, 0);
    model_rd = 32'hDEAD_BEEF;
    n_checks++;
    if (o_stall_cnt !== 2 || o_stall_err !== 0) begin
      n_fail++;
      $display("FAIL lw_stall: stall cycles=%0d pattern errors=%0d expected 2 0", o_stall_cnt, o_stall_err);
    end
    n_checks++;
    if (o_rd !== 32'hDEAD_BEEF || o_addr !== 32'h100 || o_wr !== 1'b0 || o_size !== 2'd2 || o_wstrb !== 4'd0) begin
      n_fail++;
      $display("FAIL lw_data: rd=%h addr=%h wr=%b size=%0d wstrb=%b expected deadbeef 100 0 2 0000",
               o_rd, o_addr, o_wr, o_size, o_wstrb);
    end
    for (int i = 0; i < 3; i++) begin
      run_access(ops[i], ads[i], $urandom, 32'h8011_2233, 0, 0, 0);
      model_rd = exps[i];
      n_checks++;
      if (o_rd !== exps[i]) begin
        n_fail++;
        $display("FAIL load_ext_%0d: got %h expected %h", i, o_rd, exps[i]);
      end
    end
  endtask

  task automatic test_stores();
    run_access(OP_SB, 32'h101, 32'h0000_00A5, $urandom, 0, 0, 0);
    n_checks++;
    if (o_wdata !== 32'hA5A5_A5A5 || o_wstrb !== 4'b0010 || o_size !== 2'd0 || o_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_format: wdata=%h wstrb=%b size=%0d wr=%b expected a5a5a5a5 0010 0 1",
               o_wdata, o_wstrb, o_size, o_wr);
    end
    n_checks++;
    if (o_rd !== model_rd) begin
      n_fail++;
      $display("FAIL store_keeps_rd: got %h expected %h", o_rd, model_rd);
    end
    run_access(OP_SH, 32'h102, 32'h0000_1234, $urandom, 0, 0, 0);
    n_checks++;
    if (o_wdata !== 32'h1234_1234 || o_wstrb !== 4'b1100 || o_size !== 2'd1) begin
      n_fail++;
      $display("FAIL sh_format: wdata=%h wstrb=%b size=%0d expected 12341234 1100 1", o_wdata, o_wstrb, o_size);
    end
  endtask

  task automatic test_slow_bus();
    logic [31:0] raw;
    raw = $urandom;
    run_access(OP_LW, 32'h0000_0200, $urandom, raw, 3, 1, 0);
    model_rd = raw;
    n_checks++;
    if (o_stall_cnt !== 6 || o_stall_err !== 0) begin
      n_fail++;
      $display("FAIL slow_stall: stall cycles=%0d pattern errors=%0d expected 6 0", o_stall_cnt, o_stall_err);
    end
    n_checks++;
    if (o_req_cnt !== 4 || o_stable !== 1'b1 || o_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL slow_req_hold: req cycles=%0d stable=%b addr=%h expected 4 1 200", o_req_cnt, o_stable, o_addr);
    end
    n_checks++;
    if (o_rd !== raw) begin
      n_fail++;
      $display("FAIL slow_rd: got %h expected %h", o_rd, raw);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops[5] = '{OP_LW, OP_SH, OP_LW, OP_SH, OP_LW};
    logic [31:0] ads[5] = '{32'h102, 32'h101, 32'h102, 32'h101, 32'h100};
    logic        fls[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        eal[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        eas[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      memenM = 1'b1; memopM = ops[i]; addrM = ads[i]; flushM = fls[i];
      @(negedge clk);
      n_checks++;
      if (adelM !== eal[i] || adesM !== eas[i] || data_req !== 1'b0 || stallreq !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_%0d: adel=%b ades=%b req=%b stall=%b expected %b %b 0 0",
                 i, adelM, adesM, data_req, stallreq, eal[i], eas[i]);
      end
      @(posedge clk); #1;
    end
    memenM = 1'b0; flushM = 1'b0;
  endtask

  task automatic test_done_hold();
    logic [31:0] raw;
    raw = $urandom | 32'h1;
    run_access(OP_LW, 32'h40, $urandom, raw, 0, 0, 2);
    model_rd = raw;
    n_checks++;
    if (o_req_cnt !== 1 || o_stall_err !== 0) begin
      n_fail++;
      $display("FAIL done_hold_req: req cycles=%0d stall errors=%0d expected 1 0", o_req_cnt, o_stall_err);
    end
    n_checks++;
    if (o_rd !== raw || o_rd_stable !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold_rd: rd=%h stable=%b expected %h 1", o_rd, o_rd_stable, raw);
    end
  endtask

  task automatic test_reset_in_data();
    memenM = 1'b1; memopM = OP_LW; addrM = 32'h300; writedataM = 32'h5555_AAAA; flushM = 1'b0;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_data_stall: stallreq=%b expected 0", stallreq);
    end
    @(posedge clk); #1;
    rst = 1'b0; memenM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (readdataM !== 32'h0 || data_req !== 1'b0 || data_addr !== 32'h0 || data_wstrb !== 4'h0 ||
        data_size !== 2'd0 || data_wdata !== 32'h0 || data_wr !== 1'b0 || stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_data_vals: rd=%h req=%b addr=%h wstrb=%b size=%0d wdata=%h wr=%b stall=%b expected all 0",
               readdataM, data_req, data_addr, data_wstrb, data_size, data_wdata, data_wr, stallreq);
    end
    @(posedge clk); #1;
    model_rd = 32'h0;
  endtask

  task automatic test_back_to_back_random();
    logic [2:0]  op;
    logic [31:0] addr, wd, raw;
    int alat, dlat, hold, bad;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      addr = $urandom;
      if (exp_size(op) == 2'd1) addr = addr & 32'hFFFF_FFFE;
      if (exp_size(op) == 2'd2) addr = addr & 32'hFFFF_FFFC;
      wd = $urandom; raw = $urandom;
      alat = $urandom_range(0, 3); dlat = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      run_access(op, addr, wd, raw, alat, dlat, hold);
      if (op < OP_SB) model_rd = exp_load(op, addr, raw);
      bad = 0;
      if (o_stall_cnt !== alat + dlat + 2 || o_stall_err !== 0) bad = bad | 1;
      if (o_req_cnt !== alat + 1 || o_stable !== 1'b1) bad = bad | 2;
      if (o_wr !== (op >= OP_SB) || o_size !== exp_size(op) || o_addr !== addr ||
          o_wstrb !== exp_wstrb(op, addr)) bad = bad | 4;
      if (op >= OP_SB && o_wdata !== exp_wdata(op, wd)) bad = bad | 8;
      if (o_rd !== model_rd || o_rd_stable !== 1'b1) bad = bad | 16;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_%0d: op=%0d addr=%h code=%0d stall=%0d req=%0d wr=%b size=%0d wstrb=%b wdata=%h rd=%h expected stall=%0d req=%0d wr=%b size=%0d wstrb=%b wdata=%h rd=%h",
                 i, op, addr, bad, o_stall_cnt, o_req_cnt, o_wr, o_size, o_wstrb, o_wdata, o_rd,
                 alat + dlat + 2, alat + 1, (op >= OP_SB), exp_size(op), exp_wstrb(op, addr),
                 exp_wdata(op, wd), model_rd);
      end
    end
  endtask

  initial begin
    rst = 1'b1; memenM = 1'b0; memopM = 3'd0; addrM = 32'h0; writedataM = 32'h0;
    flushM = 1'b0; pipe_holdM = 1'b0; data_addr_ok = 1'b0; data_ok = 1'b0; data_rdata = 32'h0;
    model_rd = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_stores();
    test_slow_bus();
    test_misaligned();
    test_done_hold();
    test_reset_in_data();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
